dma_mem_cycle_seq: RTL

Parametrised DMA memory-cycle sequencer for the Slipstream DMA block, the multi-channel successor to the original two-flop DMA cycle controller. It arbitrates up to NCH DMA channels round-robin and performs the bus request/acknowledge handshake with the CPU. For each granted transfer it generates the memory strobes (MREQL, RDL or WRL) and the address/data-drive enable ST23L, including programmable and externally extended wait states. Back-to-back bursts run without releasing the bus.

---
 rtl/dma_mem_cycle_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dma_mem_cycle_seq.sv
`default_nettype none
// ============================================================================
// Module   : dma_mem_cycle_seq
// Brief    : Round-robin multi-channel DMA memory-cycle sequencer with bus
//            request/acknowledge handshake and wait-state strobe generation.
// Revision : 1.0 - initial release
// ============================================================================
module dma_mem_cycle_seq #(
  parameter int NCH   = 2,
  parameter int WAITW = 2
) (
  input  logic             MasterClock,
  input  logic             RESETL,
  input  logic             CE,
  input  logic [NCH-1:0]   REQ,
  input  logic [NCH-1:0]   WR,
  input  logic [WAITW-1:0] WSCNT,
  input  logic             BAK,
  input  logic             WAIT,
  output logic             BRQ,
  output logic [NCH-1:0]   GNT,
  output logic [NCH-1:0]   DONE,
  output logic             MREQL,
  output logic             RDL,
  output logic             WRL,
  output logic             ST23L,
  output logic [2:0]       DMC
);

  localparam int                  c_ptr_w = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSREQ = 3'd1,
    S_ADDR   = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_ptr_w-1:0] r_ptr;
  logic [NCH-1:0]     r_gnt;
  logic [NCH-1:0]     r_done;
  logic               r_wr;
  logic [WAITW-1:0]   r_cnt;
  logic               r_brq;
  logic               r_mreql;
  logic               r_rdl;
  logic               r_wrl;
  logic               r_st23l;

  state_t             w_next;
  logic               w_load;
  logic               w_busy_nxt;
  logic [NCH-1:0]     w_cand;
  logic [c_ptr_w-1:0] w_win;
  logic [c_ptr_w-1:0] w_ptr_nxt;
  logic [NCH-1:0]     w_win_oh;

  // First set request at or after ptr, wrapping; scanning downward lets the
  // closest candidate overwrite farther ones.
  function automatic logic [c_ptr_w-1:0] rr_pick(input logic [NCH-1:0]     req,
                                                 input logic [c_ptr_w-1:0] ptr);
    logic [c_ptr_w-1:0] win;
    win = ptr;
    for (int i = NCH - 1; i >= 0; i--) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (req[idx[c_ptr_w-1:0]]) win = idx[c_ptr_w-1:0];
    end
    return win;
  endfunction

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    // During HOLD the channel just served steps aside so others get a turn.
    w_cand   = (r_state == S_HOLD) ? (REQ & ~r_gnt) : REQ;
    w_win    = rr_pick(w_cand, r_ptr);
    w_win_oh = '0;
    w_win_oh[w_win] = 1'b1;
    w_ptr_nxt = (w_win == c_last) ? '0 : w_win + 1'b1;

    case (r_state)
      S_IDLE:   if (|REQ) w_next = S_BUSREQ;
      S_BUSREQ: begin
        if (!(|REQ)) begin
          w_next = S_IDLE;
        end else if (BAK) begin
          w_next = S_ADDR;
          w_load = 1'b1;
        end
      end
      S_ADDR:   w_next = S_STROBE;
      S_STROBE: if (r_cnt == '0 && !WAIT) w_next = S_HOLD;
      S_HOLD: begin
        if (BAK && (|w_cand)) begin
          w_next = S_ADDR;
          w_load = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default:  w_next = S_IDLE;
    endcase

    w_busy_nxt = (w_next == S_ADDR) || (w_next == S_STROBE) || (w_next == S_HOLD);
  end

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_wr    <= 1'b0;
      r_cnt   <= '0;
      r_brq   <= 1'b0;
      r_mreql <= 1'b1;
      r_rdl   <= 1'b1;
      r_wrl   <= 1'b1;
      r_st23l <= 1'b1;
    end else if (CE) begin
      r_state <= w_next;
      if (w_load) begin
        r_gnt <= w_win_oh;
        r_wr  <= WR[w_win];
        r_cnt <= WSCNT;
        r_ptr <= w_ptr_nxt;
      end else begin
        if (r_state == S_STROBE && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        if (!w_busy_nxt) r_gnt <= '0;
      end
      // Outputs decode the state being entered so they line up with DMC.
      r_brq   <= (w_next != S_IDLE);
      r_st23l <= !w_busy_nxt;
      r_mreql <= !(w_next == S_STROBE);
      r_rdl   <= !((w_next == S_STROBE) && !r_wr);
      r_wrl   <= !((w_next == S_STROBE) && r_wr);
      r_done  <= (w_next == S_HOLD) ? r_gnt : '0;
    end
  end

  assign BRQ   = r_brq;
  assign GNT   = r_gnt;
  assign DONE  = r_done;
  assign MREQL = r_mreql;
  assign RDL   = r_rdl;
  assign WRL   = r_wrl;
  assign ST23L = r_st23l;
  assign DMC   = r_state;

endmodule
`default_nettype wire
